// File: rtl/packet_fifo.sv
// Single-clock 4-deep packet-word FIFO with registered read data and over/underflow protection.
// Optional sticky error flags are added when FIFO_ERR_FLAGS_EN is defined.
// purpose: buffer WIDTH-bit words between scheduler and one lane's output logic
// latency: q updates 1 clock after an accepted rdreq; flags are combinational from state
// backpressure: writes while full are dropped unless a read is accepted in the same cycle
module packet_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic             wrreq,
   input  logic             rdreq,
   output logic [WIDTH-1:0] q,
   output logic             empty,
   output logic             full,
   output logic [AW-1:0]    usedw
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             wr_ok, rd_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign usedw = count_q[AW-1:0];
   assign q     = q_q;

   // A full FIFO still takes a write when the same cycle frees a slot.
   always_comb begin
      rd_ok    = rdreq & ~empty;
      wr_ok    = wrreq & (~full | rd_ok);
      wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      q_d      = rd_ok ? mem[rd_ptr_q] : q_q;
      count_d  = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         q_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         q_q      <= q_d;
      end
   end

   // Storage is not cleared by reset, but reset still blocks a same-cycle write.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem[wr_ptr_q] <= data;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_q  | (wrreq & ~wr_ok);
         underflow_q <= underflow_q | (rdreq & ~rd_ok);
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_packet_fifo.sv
// Self-checking bench for packet_fifo: directed scenarios plus random traffic against a queue model.
// Flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_packet_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] data;
   logic             wrreq;
   logic             rdreq;
   logic [WIDTH-1:0] q;
   logic             empty;
   logic             full;
   logic [AW-1:0]    usedw;
`ifdef FIFO_ERR_FLAGS_EN
   logic             overflow;
   logic             underflow;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: contents as a queue, plus the last popped word and sticky flags.
   logic [WIDTH-1:0] mq [$];
   logic [WIDTH-1:0] q_m;
   logic             ov_m;
   logic             un_m;

   always #5 clk = ~clk;

   packet_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .data  (data),
      .wrreq (wrreq),
      .rdreq (rdreq),
      .q     (q),
      .empty (empty),
      .full  (full),
      .usedw (usedw)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".q"},     q,                     q_m);
      check({tag, ".empty"}, 32'(empty),            32'(mq.size() == 0));
      check({tag, ".full"},  32'(full),             32'(mq.size() == DEPTH));
      check({tag, ".usedw"}, 32'(usedw),            32'(mq.size() % DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
      check({tag, ".ovf"},   32'(overflow),         32'(ov_m));
      check({tag, ".unf"},   32'(underflow),        32'(un_m));
`endif
   endtask

   // One clock: drive, update model at the edge, then compare #1 later.
   task automatic cycle(input string tag, input logic w, input logic [WIDTH-1:0] d,
                        input logic r, input logic rst);
      bit can_rd, can_wr;
      reset = rst;
      wrreq = w;
      data  = d;
      rdreq = r;
      @(posedge clk);
      can_rd = r && (mq.size() > 0);
      can_wr = w && ((mq.size() < DEPTH) || can_rd);
      if (rst) begin
         mq.delete();
         q_m  = '0;
         ov_m = 1'b0;
         un_m = 1'b0;
      end else begin
         if (w && !can_wr) ov_m = 1'b1;
         if (r && !can_rd) un_m = 1'b1;
         if (can_rd) q_m = mq.pop_front();
         if (can_wr) mq.push_back(d);
      end
      #1;
      reset = 1'b0;
      wrreq = 1'b0;
      rdreq = 1'b0;
      check_state(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] w0;
      reset = 1'b1;
      wrreq = 1'b0;
      rdreq = 1'b0;
      data  = '0;
      q_m   = '0;
      ov_m  = 1'b0;
      un_m  = 1'b0;

      // 1: reset then idle
      cycle("rst", 1'b0, '0, 1'b0, 1'b1);
      cycle("idle", 1'b0, '0, 1'b0, 1'b0);
      check("idle.q_zero", q, 32'h0);
      check("idle.empty_one", 32'(empty), 32'd1);

      // 2: three writes, three pops
      cycle("t2w", 1'b1, 32'hA1, 1'b0, 1'b0);
      cycle("t2w", 1'b1, 32'hA2, 1'b0, 1'b0);
      cycle("t2w", 1'b1, 32'hA3, 1'b0, 1'b0);
      cycle("t2r", 1'b0, '0, 1'b1, 1'b0);
      check("t2.q_a1", q, 32'hA1);
      cycle("t2r", 1'b0, '0, 1'b1, 1'b0);
      check("t2.q_a2", q, 32'hA2);
      cycle("t2r", 1'b0, '0, 1'b1, 1'b0);
      check("t2.q_a3", q, 32'hA3);
      check("t2.empty", 32'(empty), 32'd1);

      // 3: fill, drop a fifth write, drain
      for (int i = 0; i < 4; i++) cycle("t3w", 1'b1, 32'hB0 + i, 1'b0, 1'b0);
      check("t3.full", 32'(full), 32'd1);
      check("t3.usedw0", 32'(usedw), 32'd0);
      cycle("t3drop", 1'b1, 32'hDEAD, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle("t3r", 1'b0, '0, 1'b1, 1'b0);
         check("t3.order", q, 32'hB0 + i);
      end

      // 4: simultaneous read+write while full
      for (int i = 0; i < 4; i++) cycle("t4w", 1'b1, 32'hC0 + i, 1'b0, 1'b0);
      cycle("t4rw", 1'b1, 32'h55, 1'b1, 1'b0);
      check("t4.q_oldest", q, 32'hC0);
      check("t4.full_kept", 32'(full), 32'd1);
      for (int i = 0; i < 4; i++) cycle("t4r", 1'b0, '0, 1'b1, 1'b0);
      check("t4.last_55", q, 32'h55);

      // 5: simultaneous read+write while empty, then underflow
      w0 = q;
      cycle("t5rw", 1'b1, 32'h77, 1'b1, 1'b0);
      check("t5.q_held", q, w0);
      check("t5.usedw1", 32'(usedw), 32'd1);
      cycle("t5r", 1'b0, '0, 1'b1, 1'b0);
      check("t5.q_77", q, 32'h77);
      cycle("t5unf", 1'b0, '0, 1'b1, 1'b0);
      check("t5.q_still", q, 32'h77);

      // 6: reset with wrreq while holding two words
      cycle("t6w", 1'b1, 32'h11, 1'b0, 1'b0);
      cycle("t6w", 1'b1, 32'h22, 1'b0, 1'b0);
      cycle("t6rst", 1'b1, 32'h33, 1'b0, 1'b1);
      check("t6.empty", 32'(empty), 32'd1);
      cycle("t6w", 1'b1, 32'h99, 1'b0, 1'b0);
      cycle("t6r", 1'b0, '0, 1'b1, 1'b0);
      check("t6.q_99", q, 32'h99);

      // Random traffic in write-heavy, read-heavy and balanced phases
      for (int i = 0; i < 3000; i++) begin
         int ph;
         int pw;
         ph = (i / 150) % 3;
         pw = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
         cycle("rnd",
               logic'($urandom_range(99) < pw),
               $urandom,
               logic'($urandom_range(99) < (100 - pw)),
               logic'($urandom_range(499) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 ns");
      $fatal(1);
   end
endmodule
